approx_mult_err_monitor: RTL and testbench

//  Sits directly downstream of the 4x4 approximate multiplier. It takes each operand pair
//  (A,B) and the approximate product R, and computes the exact product A*B. It accumulates

---
 rtl/approx_mult_err_monitor.sv | 159 +++++++++++++++
 tb/tb_approx_mult_err_monitor.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mult_err_monitor.sv
//------------------------------------------------------------------------------
// approx_mult_err_monitor
//    Accumulates ER/MED/WCE error metrics of a 4x4 approximate multiplier over a window.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module approx_mult_err_monitor #(
   parameter int N_SAMPLES = 256,
   parameter int CNT_W     = 9,
   parameter int SUM_W     = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [3:0]       in_a_i,
   input  logic [3:0]       in_b_i,
   input  logic [7:0]       in_r_i,
   output logic [CNT_W-1:0] sample_cnt_o,
   output logic [CNT_W-1:0] err_cnt_o,
   output logic [SUM_W-1:0] sum_ed_o,
   output logic [7:0]       max_ed_o,
   output logic [3:0]       max_a_o,
   output logic [3:0]       max_b_o,
   output logic             done_o
);

   localparam logic [CNT_W-1:0] C_N_SAMPLES = CNT_W'(N_SAMPLES);

   logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
   logic             s1_valid_q, s1_valid_d;
   logic             s1_err_q, s1_err_d;
   logic [7:0]       s1_ed_q, s1_ed_d;
   logic [3:0]       s1_a_q, s1_a_d;
   logic [3:0]       s1_b_q, s1_b_d;
   logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [SUM_W-1:0] sum_ed_q, sum_ed_d;
   logic [7:0]       max_ed_q, max_ed_d;
   logic [3:0]       max_a_q, max_a_d;
   logic [3:0]       max_b_q, max_b_d;
   logic             done_q, done_d;

   logic             w_accept;
   logic [7:0]       w_exact;
   logic [7:0]       w_ed;
   logic [SUM_W:0]   w_sum_ext;
   logic [SUM_W-1:0] w_sum_sat;
   logic [CNT_W-1:0] w_sample_inc;

   // The accept counter alone gates intake, so exactly N_SAMPLES enter the pipeline.
   assign in_ready_o   = (acc_cnt_q != C_N_SAMPLES);
   assign w_accept     = in_valid_i & in_ready_o;
   assign w_exact      = {4'h0, in_a_i} * {4'h0, in_b_i};
   assign w_ed         = (w_exact >= in_r_i) ? (w_exact - in_r_i) : (in_r_i - w_exact);
   assign w_sum_ext    = {1'b0, sum_ed_q} + (SUM_W+1)'(s1_ed_q);
   assign w_sum_sat    = w_sum_ext[SUM_W] ? {SUM_W{1'b1}} : w_sum_ext[SUM_W-1:0];
   assign w_sample_inc = sample_cnt_q + 1'b1;

   always_comb begin
      acc_cnt_d    = acc_cnt_q;
      s1_valid_d   = w_accept;
      s1_err_d     = s1_err_q;
      s1_ed_d      = s1_ed_q;
      s1_a_d       = s1_a_q;
      s1_b_d       = s1_b_q;
      sample_cnt_d = sample_cnt_q;
      err_cnt_d    = err_cnt_q;
      sum_ed_d     = sum_ed_q;
      max_ed_d     = max_ed_q;
      max_a_d      = max_a_q;
      max_b_d      = max_b_q;
      done_d       = done_q;

      if (w_accept) begin
         acc_cnt_d = acc_cnt_q + 1'b1;
         s1_ed_d   = w_ed;
         s1_err_d  = (w_ed != 8'h00);
         s1_a_d    = in_a_i;
         s1_b_d    = in_b_i;
      end

      if (s1_valid_q) begin
         sample_cnt_d = w_sample_inc;
         err_cnt_d    = err_cnt_q + CNT_W'(s1_err_q);
         sum_ed_d     = w_sum_sat;
         // Strict compare keeps the earliest sample on ties.
         if (s1_ed_q > max_ed_q) begin
            max_ed_d = s1_ed_q;
            max_a_d  = s1_a_q;
            max_b_d  = s1_b_q;
         end
         if (w_sample_inc == C_N_SAMPLES) begin
            done_d = 1'b1;
         end
      end

      if (clr_i) begin
         acc_cnt_d    = '0;
         s1_valid_d   = 1'b0;
         s1_err_d     = 1'b0;
         s1_ed_d      = '0;
         s1_a_d       = '0;
         s1_b_d       = '0;
         sample_cnt_d = '0;
         err_cnt_d    = '0;
         sum_ed_d     = '0;
         max_ed_d     = '0;
         max_a_d      = '0;
         max_b_d      = '0;
         done_d       = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_cnt_q    <= '0;
         s1_valid_q   <= 1'b0;
         s1_err_q     <= 1'b0;
         s1_ed_q      <= '0;
         s1_a_q       <= '0;
         s1_b_q       <= '0;
         sample_cnt_q <= '0;
         err_cnt_q    <= '0;
         sum_ed_q     <= '0;
         max_ed_q     <= '0;
         max_a_q      <= '0;
         max_b_q      <= '0;
         done_q       <= 1'b0;
      end else begin
         acc_cnt_q    <= acc_cnt_d;
         s1_valid_q   <= s1_valid_d;
         s1_err_q     <= s1_err_d;
         s1_ed_q      <= s1_ed_d;
         s1_a_q       <= s1_a_d;
         s1_b_q       <= s1_b_d;
         sample_cnt_q <= sample_cnt_d;
         err_cnt_q    <= err_cnt_d;
         sum_ed_q     <= sum_ed_d;
         max_ed_q     <= max_ed_d;
         max_a_q      <= max_a_d;
         max_b_q      <= max_b_d;
         done_q       <= done_d;
      end
   end

   assign sample_cnt_o = sample_cnt_q;
   assign err_cnt_o    = err_cnt_q;
   assign sum_ed_o     = sum_ed_q;
   assign max_ed_o     = max_ed_q;
   assign max_a_o      = max_a_q;
   assign max_b_o      = max_b_q;
   assign done_o       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_approx_mult_err_monitor.sv
//------------------------------------------------------------------------------
// tb_approx_mult_err_monitor
//    Directed self-checking bench for approx_mult_err_monitor.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_approx_mult_err_monitor;

   logic       clk;
   logic       rst_n;
   logic       clr;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_a;
   logic [3:0] in_b;
   logic [7:0] in_r;
   logic [8:0] sample_cnt;
   logic [8:0] err_cnt;
   logic [15:0] sum_ed;
   logic [7:0] max_ed;
   logic [3:0] max_a;
   logic [3:0] max_b;
   logic       done;

   // Second instance with a narrow accumulator to reach saturation quickly.
   logic       clr8;
   logic       in_valid8;
   logic       in_ready8;
   logic [3:0] in_a8;
   logic [3:0] in_b8;
   logic [7:0] in_r8;
   logic [8:0] sample_cnt8;
   logic [8:0] err_cnt8;
   logic [7:0] sum_ed8;
   logic [7:0] max_ed8;
   logic [3:0] max_a8;
   logic [3:0] max_b8;
   logic       done8;

   int n_checks = 0;
   int n_errors = 0;

   approx_mult_err_monitor #(.N_SAMPLES(256), .CNT_W(9), .SUM_W(16)) dut (
      .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .in_a_i(in_a), .in_b_i(in_b), .in_r_i(in_r), .sample_cnt_o(sample_cnt), .err_cnt_o(err_cnt),
      .sum_ed_o(sum_ed), .max_ed_o(max_ed), .max_a_o(max_a), .max_b_o(max_b), .done_o(done)
   );

   approx_mult_err_monitor #(.N_SAMPLES(256), .CNT_W(9), .SUM_W(8)) dut8 (
      .clk_i(clk), .rst_ni(rst_n), .clr_i(clr8), .in_valid_i(in_valid8), .in_ready_o(in_ready8),
      .in_a_i(in_a8), .in_b_i(in_b8), .in_r_i(in_r8), .sample_cnt_o(sample_cnt8), .err_cnt_o(err_cnt8),
      .sum_ed_o(sum_ed8), .max_ed_o(max_ed8), .max_a_o(max_a8), .max_b_o(max_b8), .done_o(done8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [7:0] r);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_r     = r;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_a     = 4'h0;
      in_b     = 4'h0;
      in_r     = 8'h00;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      step();
      clr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clr   = 1'b1;
      repeat (3) step();
      clr   = 1'b0;
      rst_n = 1'b1;
      step();
      n_checks++;
      if ({sample_cnt, err_cnt, sum_ed, max_ed, max_a, max_b, done} !== '0) begin
         n_errors++;
         $display("FAIL reset_metrics: got cnt=%0d err=%0d sum=%0d max=%0d a=%0d b=%0d done=%b, expected all 0",
                  sample_cnt, err_cnt, sum_ed, max_ed, max_a, max_b, done);
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_ready: got %b expected 1", in_ready);
      end
   endtask

   task automatic test_exact_sample();
      drive(4'd3, 4'd5, 8'd15);
      step();
      idle();
      n_checks++;
      if (sample_cnt !== 9'd0) begin
         n_errors++;
         $display("FAIL latency_one_cycle: sample_cnt got %0d expected 0", sample_cnt);
      end
      step();
      n_checks++;
      if (sample_cnt !== 9'd1 || err_cnt !== 9'd0 || sum_ed !== 16'd0 || max_ed !== 8'd0) begin
         n_errors++;
         $display("FAIL exact_sample: got cnt=%0d err=%0d sum=%0d max=%0d expected 1/0/0/0",
                  sample_cnt, err_cnt, sum_ed, max_ed);
      end
   endtask

   task automatic test_errors();
      do_clr();
      drive(4'd15, 4'd15, 8'hE0);
      step();
      drive(4'd7, 4'd9, 8'h3C);
      step();
      idle();
      n_checks++;
      if (sample_cnt !== 9'd1 || sum_ed !== 16'd1 || max_ed !== 8'd1 || max_a !== 4'd15 || max_b !== 4'd15) begin
         n_errors++;
         $display("FAIL errors_first: got cnt=%0d sum=%0d max=%0d a=%0d b=%0d expected 1/1/1/15/15",
                  sample_cnt, sum_ed, max_ed, max_a, max_b);
      end
      step();
      n_checks++;
      if (sample_cnt !== 9'd2 || err_cnt !== 9'd2 || sum_ed !== 16'd4) begin
         n_errors++;
         $display("FAIL errors_counts: got cnt=%0d err=%0d sum=%0d expected 2/2/4", sample_cnt, err_cnt, sum_ed);
      end
      n_checks++;
      if (max_ed !== 8'd3 || max_a !== 4'd7 || max_b !== 4'd9) begin
         n_errors++;
         $display("FAIL errors_max: got max=%0d a=%0d b=%0d expected 3/7/9", max_ed, max_a, max_b);
      end
   endtask

   task automatic test_tie();
      do_clr();
      drive(4'd2, 4'd2, 8'd6);
      step();
      drive(4'd1, 4'd1, 8'd3);
      step();
      idle();
      step();
      n_checks++;
      if (max_ed !== 8'd2 || max_a !== 4'd2 || max_b !== 4'd2) begin
         n_errors++;
         $display("FAIL tie_keep_first: got max=%0d a=%0d b=%0d expected 2/2/2", max_ed, max_a, max_b);
      end
      n_checks++;
      if (err_cnt !== 9'd2 || sum_ed !== 16'd4) begin
         n_errors++;
         $display("FAIL tie_sums: got err=%0d sum=%0d expected 2/4", err_cnt, sum_ed);
      end
   endtask

   task automatic test_exhaustive();
      int         bad_ready;
      logic [7:0] idx;
      bad_ready = 0;
      do_clr();
      for (int i = 0; i < 256; i++) begin
         idx = 8'(i);
         drive(idx[7:4], idx[3:0], {4'h0, idx[7:4]} * {4'h0, idx[3:0]});
         if (in_ready !== 1'b1) bad_ready++;
         step();
      end
      n_checks++;
      if (bad_ready != 0) begin
         n_errors++;
         $display("FAIL window_ready_high: in_ready low on %0d cycles, expected 0", bad_ready);
      end
      n_checks++;
      if (in_ready !== 1'b0 || done !== 1'b0 || sample_cnt !== 9'd255) begin
         n_errors++;
         $display("FAIL window_ready_drop: got ready=%b done=%b cnt=%0d expected 0/0/255",
                  in_ready, done, sample_cnt);
      end
      drive(4'd1, 4'd1, 8'd0);
      step();
      n_checks++;
      if (done !== 1'b1 || sample_cnt !== 9'd256 || err_cnt !== 9'd0 || sum_ed !== 16'd0 || max_ed !== 8'd0) begin
         n_errors++;
         $display("FAIL window_done: got done=%b cnt=%0d err=%0d sum=%0d max=%0d expected 1/256/0/0/0",
                  done, sample_cnt, err_cnt, sum_ed, max_ed);
      end
      repeat (3) step();
      n_checks++;
      if (done !== 1'b1 || in_ready !== 1'b0 || sample_cnt !== 9'd256 || err_cnt !== 9'd0 || sum_ed !== 16'd0) begin
         n_errors++;
         $display("FAIL window_frozen: got done=%b ready=%b cnt=%0d err=%0d sum=%0d expected 1/0/256/0/0",
                  done, in_ready, sample_cnt, err_cnt, sum_ed);
      end
      do_clr();
      idle();
      n_checks++;
      if (done !== 1'b0 || in_ready !== 1'b1 || sample_cnt !== 9'd0) begin
         n_errors++;
         $display("FAIL window_clr: got done=%b ready=%b cnt=%0d expected 0/1/0", done, in_ready, sample_cnt);
      end
   endtask

   task automatic test_saturation();
      in_valid8 = 1'b1;
      in_a8     = 4'd0;
      in_b8     = 4'd0;
      in_r8     = 8'hFF;
      step();
      step();
      in_valid8 = 1'b0;
      n_checks++;
      if (sum_ed8 !== 8'd255 || sample_cnt8 !== 9'd1) begin
         n_errors++;
         $display("FAIL sat_first: got sum=%0d cnt=%0d expected 255/1", sum_ed8, sample_cnt8);
      end
      step();
      n_checks++;
      if (sum_ed8 !== 8'd255 || max_ed8 !== 8'd255 || sample_cnt8 !== 9'd2 || err_cnt8 !== 9'd2) begin
         n_errors++;
         $display("FAIL sat_sum: got sum=%0d max=%0d cnt=%0d err=%0d expected 255/255/2/2",
                  sum_ed8, max_ed8, sample_cnt8, err_cnt8);
      end
   endtask

   task automatic test_clr_in_flight();
      do_clr();
      drive(4'd2, 4'd3, 8'd0);
      step();
      drive(4'd4, 4'd4, 8'd0);
      step();
      n_checks++;
      if (sample_cnt !== 9'd1 || sum_ed !== 16'd6) begin
         n_errors++;
         $display("FAIL clr_setup: got cnt=%0d sum=%0d expected 1/6", sample_cnt, sum_ed);
      end
      drive(4'd5, 4'd5, 8'd0);
      clr = 1'b1;
      step();
      clr = 1'b0;
      idle();
      n_checks++;
      if ({sample_cnt, err_cnt, sum_ed, max_ed, max_a, max_b, done} !== '0 || in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL clr_immediate: got cnt=%0d err=%0d sum=%0d max=%0d done=%b ready=%b expected 0s, ready 1",
                  sample_cnt, err_cnt, sum_ed, max_ed, done, in_ready);
      end
      repeat (2) step();
      n_checks++;
      if (sample_cnt !== 9'd0 || sum_ed !== 16'd0 || max_ed !== 8'd0) begin
         n_errors++;
         $display("FAIL clr_dropped: got cnt=%0d sum=%0d max=%0d expected 0/0/0", sample_cnt, sum_ed, max_ed);
      end
      drive(4'd3, 4'd5, 8'd14);
      step();
      idle();
      step();
      n_checks++;
      if (sample_cnt !== 9'd1 || err_cnt !== 9'd1 || sum_ed !== 16'd1 || max_ed !== 8'd1 ||
          max_a !== 4'd3 || max_b !== 4'd5) begin
         n_errors++;
         $display("FAIL clr_resume: got cnt=%0d err=%0d sum=%0d max=%0d a=%0d b=%0d expected 1/1/1/1/3/5",
                  sample_cnt, err_cnt, sum_ed, max_ed, max_a, max_b);
      end
   endtask

   task automatic test_async_reset();
      drive(4'd15, 4'd1, 8'd0);
      step();
      step();
      idle();
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (sample_cnt !== 9'd0 || sum_ed !== 16'd0 || max_ed !== 8'd0) begin
         n_errors++;
         $display("FAIL async_reset: got cnt=%0d sum=%0d max=%0d expected 0/0/0", sample_cnt, sum_ed, max_ed);
      end
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b0;
      clr       = 1'b0;
      clr8      = 1'b0;
      in_valid8 = 1'b0;
      in_a8     = 4'h0;
      in_b8     = 4'h0;
      in_r8     = 8'h00;
      idle();
      test_reset();
      test_exact_sample();
      test_errors();
      test_tie();
      test_exhaustive();
      test_saturation();
      test_clr_in_flight();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
